// File: rtl/melody_gate.sv
// -----------------------------------------------------------------------------
// melody_gate
//
// Plays a fixed 16-entry song by routing one of the note-tone square waves
// from the divider bank to the buzzer pin at a time. Each ROM entry gives a
// note, a duration in beats, a rest flag and an end-of-song flag. Every entry
// is followed by an optional silent gap. All tone inputs come from dividers
// clocked by clock_in, so no synchronisers are needed on tone_in.
//
// ROM entry layout: {end, rest, dur_m1[2:0], note[2:0]}
//   end    : last entry of the song (loop back to entry 0 or finish)
//   rest   : entry plays silence for its duration
//   dur_m1 : duration in beats minus one
//   note   : index into tone_in
//
// Ports
//   clock_in  in   system clock (50 MHz)
//   reset     in   synchronous, active-high reset
//   start     in   begin the song from entry 0 (honoured only while idle)
//   stop      in   abort playback, wins over start
//   loop_en   in   at the end entry, restart from entry 0 instead of finishing
//   tone_in   in   NOTES tone square waves, bit i is note i
//   speaker   out  registered, gated tone output
//   busy      out  high while an entry is being loaded, played or gapped
//   done      out  one-cycle pulse when the song finishes normally
//   song_pos  out  index of the current ROM entry
//   note_idx  out  note field of the current entry
// -----------------------------------------------------------------------------
module melody_gate #(
    parameter int NOTES       = 8,
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [NOTES-1:0] tone_in,
    output logic             speaker,
    output logic             busy,
    output logic             done,
    output logic [3:0]       song_pos,
    output logic [2:0]       note_idx
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_PLAY = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Terminal counts for the 32-bit unsigned cycle and gap counters.
    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

    // -------------------------------------------------------------------------
    // Song ROM
    // -------------------------------------------------------------------------
    function automatic logic [7:0] rom_entry(input logic [3:0] addr);
        logic [7:0] data;
        case (addr)
            4'd0:    data = 8'h00;  // note 0, 1 beat
            4'd1:    data = 8'h0A;  // note 2, 2 beats
            4'd2:    data = 8'h40;  // rest, 1 beat
            4'd3:    data = 8'h04;  // note 4, 1 beat
            4'd4:    data = 8'h9F;  // note 7, 4 beats, end of song
            default: data = 8'hC0;  // unused slots: silent end markers
        endcase
        return data;
    endfunction

    // Select tone_in[note] without indexing past the physical tone bus.
    function automatic logic tone_pick(input logic [NOTES-1:0] tones,
                                       input logic [2:0]       note);
        logic bit_sel;
        bit_sel = 1'b0;
        for (int i = 0; i < NOTES; i++) begin
            if (note == 3'(i)) begin
                bit_sel = tones[i];
            end
        end
        return bit_sel;
    endfunction

    // A note field beyond the populated tone bus plays as silence.
    function automatic logic note_in_range(input logic [2:0] note);
        return (32'(note) < 32'(NOTES));
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t      state_q;
    state_t      state_d;
    state_t      decide_state;

    logic [7:0]  entry_q;
    logic [31:0] cyc_cnt;
    logic [31:0] beat_cnt;
    logic [31:0] gap_cnt;
    logic [3:0]  song_pos_q;
    logic        speaker_p1;

    logic        ent_end;
    logic        ent_rest;
    logic [2:0]  ent_dur;
    logic [2:0]  ent_note;
    logic        play_last;
    logic        gap_last;
    logic        take_next;
    logic        tone_now;

    assign ent_end  = entry_q[7];
    assign ent_rest = entry_q[6];
    assign ent_dur  = entry_q[5:3];
    assign ent_note = entry_q[2:0];

    // Last PLAY cycle: final cycle of the final beat of this entry.
    assign play_last = (cyc_cnt == BEAT_LAST) && (beat_cnt == {29'd0, ent_dur});
    assign gap_last  = (gap_cnt == GAP_LAST);

    // The next-entry decision is taken at the end of GAP, or straight at the
    // end of PLAY when the gap is configured away.
    assign take_next = ((state_q == S_PLAY) && play_last && !HAS_GAP) ||
                       ((state_q == S_GAP)  && gap_last);

    // loop_en only matters here, on the decision cycle itself.
    assign decide_state = (ent_end && !loop_en) ? S_DONE : S_LOAD;

    assign tone_now = tone_pick(tone_in, ent_note);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (play_last) begin
                    state_d = HAS_GAP ? S_GAP : decide_state;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = decide_state;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort from anywhere in the song; done is not pulsed on this path.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_LOAD, S_PLAY, S_GAP: busy = 1'b1;
            S_DONE:                done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Entry sequencing, beat timing and speaker gate
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_in) begin
        if (reset) begin
            entry_q    <= 8'd0;
            cyc_cnt    <= 32'd0;
            beat_cnt   <= 32'd0;
            gap_cnt    <= 32'd0;
            song_pos_q <= 4'd0;
            speaker_p1 <= 1'b0;
        end else begin
            // stage p1: speaker follows the selected tone one cycle after PLAY
            speaker_p1 <= (state_q == S_PLAY) && !stop && !ent_rest &&
                          note_in_range(ent_note) && tone_now;

            if (state_q == S_IDLE) begin
                if (start && !stop) begin
                    song_pos_q <= 4'd0;
                end
            end else if (!stop) begin
                // An aborted song freezes position, entry and counters.
                case (state_q)
                    S_LOAD: begin
                        entry_q  <= rom_entry(song_pos_q);
                        cyc_cnt  <= 32'd0;
                        beat_cnt <= 32'd0;
                    end
                    S_PLAY: begin
                        if (cyc_cnt == BEAT_LAST) begin
                            cyc_cnt  <= 32'd0;
                            beat_cnt <= beat_cnt + 32'd1;
                        end else begin
                            cyc_cnt <= cyc_cnt + 32'd1;
                        end
                        // Keep the gap counter primed for the coming GAP state.
                        gap_cnt <= 32'd0;
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                    default: begin
                    end
                endcase

                if (take_next) begin
                    if (!ent_end) begin
                        song_pos_q <= song_pos_q + 4'd1;  // wraps 15 -> 0
                    end else if (loop_en) begin
                        song_pos_q <= 4'd0;
                    end
                    // end without loop: position holds through DONE
                end
            end
        end
    end

    assign speaker  = speaker_p1;
    assign song_pos = song_pos_q;
    assign note_idx = ent_note;

endmodule
